// File: rtl/switch_debouncer.sv
// Switch conditioning for the slide-switch bank: 2-flop synchroniser, per-switch
// stable-time debounce FSM, registered busy flags and optional one-cycle edge pulses.
// Optional feature macro: SW_EDGE_PULSE_EN (when undefined, SW_RISE/SW_FALL are tied to 0).
module switch_debouncer #(
    parameter int unsigned NUM_SW          = 6,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic [0:NUM_SW-1] SW,
    output logic [0:NUM_SW-1] SW_DB,
    output logic [0:NUM_SW-1] SW_BUSY,
    output logic [0:NUM_SW-1] SW_RISE,
    output logic [0:NUM_SW-1] SW_FALL
);

    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } state_t;

    logic [0:NUM_SW-1] s1;
    logic [0:NUM_SW-1] s2;

    // Two-flop synchroniser; only s2 is used by the debounce logic
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= SW;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        state_t           state_q;
        state_t           state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             db_q;
        logic             db_d;
        logic             busy_q;
        logic             accept;

        // FSM state and stable-time counter register
        always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
            if (!RESET_N) begin
                state_q <= STABLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // Next state: a mismatch must persist DEBOUNCE_CYCLES+1 edges, any match restarts it
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                STABLE: begin
                    if (s2[i] != db_q) begin
                        state_d = PENDING;
                        cnt_d   = CNT_ONE;
                    end else begin
                        cnt_d   = '0;
                    end
                end
                PENDING: begin
                    if (s2[i] == db_q) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Output decode: accept the new level on the qualifying edge
        always_comb begin
            accept = 1'b0;
            db_d   = db_q;
            if ((state_q == PENDING) && (s2[i] != db_q) && (cnt_q == CNT_MAX)) begin
                accept = 1'b1;
                db_d   = s2[i];
            end
        end

        // Registered level and busy outputs
        always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
            if (!RESET_N) begin
                db_q   <= 1'b0;
                busy_q <= 1'b0;
            end else begin
                db_q   <= db_d;
                busy_q <= (state_d == PENDING);
            end
        end

        assign SW_DB[i]   = db_q;
        assign SW_BUSY[i] = busy_q;

`ifdef SW_EDGE_PULSE_EN
        logic rise_q;
        logic fall_q;

        // Edge pulses registered on the same edge that updates the level
        always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
            if (!RESET_N) begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                rise_q <= accept & s2[i];
                fall_q <= accept & ~s2[i];
            end
        end

        assign SW_RISE[i] = rise_q;
        assign SW_FALL[i] = fall_q;
`else
        assign SW_RISE[i] = 1'b0;
        assign SW_FALL[i] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer: directed vector table, hand-written
// corner sequences and randomized stimulus against a run-length reference model.
module tb_switch_debouncer;

    localparam int N = 6;
    localparam int D = 4;
`ifdef SW_EDGE_PULSE_EN
    localparam bit PULSE_EN = 1'b1;
`else
    localparam bit PULSE_EN = 1'b0;
`endif

    logic         CLOCK_50;
    logic         RESET_N;
    logic [0:N-1] SW;
    logic [0:N-1] SW_DB;
    logic [0:N-1] SW_BUSY;
    logic [0:N-1] SW_RISE;
    logic [0:N-1] SW_FALL;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: sync pipeline copy plus count of consecutive mismatching edges
    logic [0:N-1] m_s1, m_s2, m_db, m_busy, m_rise, m_fall;
    int           m_run [N];

    typedef struct {
        logic [0:N-1] sw;
        logic [0:N-1] db;
        logic [0:N-1] busy;
        logic [0:N-1] rise;
    } vec_t;

    vec_t tbl [8];

    switch_debouncer #(
        .NUM_SW          (N),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .SW       (SW),
        .SW_DB    (SW_DB),
        .SW_BUSY  (SW_BUSY),
        .SW_RISE  (SW_RISE),
        .SW_FALL  (SW_FALL)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [0:N-1] pmask(input logic [0:N-1] v);
        return PULSE_EN ? v : '0;
    endfunction

    task automatic check(input string name, input logic [0:N-1] act, input logic [0:N-1] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_s1 = '0; m_s2 = '0; m_db = '0; m_busy = '0; m_rise = '0; m_fall = '0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
    endtask

    // Level flips once D+1 consecutive edges have seen the synchronised input differ
    task automatic model_edge();
        if (!RESET_N) begin
            model_clear();
        end else begin
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < N; i++) begin
                if (m_s2[i] != m_db[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == D + 1) begin
                        m_db[i]   = m_s2[i];
                        m_rise[i] = PULSE_EN & m_s2[i];
                        m_fall[i] = PULSE_EN & ~m_s2[i];
                        m_run[i]  = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_busy[i] = (m_run[i] != 0);
            end
            m_s2 = m_s1;
            m_s1 = SW;
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        model_edge();
        #1;
        check("model_db",   SW_DB,   m_db);
        check("model_busy", SW_BUSY, m_busy);
        check("model_rise", SW_RISE, m_rise);
        check("model_fall", SW_FALL, m_fall);
    endtask

    // Asynchronous reset mid-cycle, held for a number of edges, released after an edge
    task automatic reset_pulse(input int cycles);
        #4;
        RESET_N = 1'b0;
        model_clear();
        #1;
        check("rst_db",   SW_DB,   '0);
        check("rst_busy", SW_BUSY, '0);
        check("rst_rise", SW_RISE, '0);
        check("rst_fall", SW_FALL, '0);
        repeat (cycles) step();
        RESET_N = 1'b1;
    endtask

    initial begin
        int rise_cnt;
        int fall_cnt;
        bit calm;
        logic [0:N-1] v;

        // Clean 0->1 step on SW[0] from reset, edge by edge
        for (int k = 0; k < 8; k++) begin
            tbl[k].sw   = 6'b100000;
            tbl[k].db   = (k >= 6) ? 6'b100000 : 6'b000000;
            tbl[k].busy = (k >= 2 && k <= 5) ? 6'b100000 : 6'b000000;
            tbl[k].rise = (k == 6) ? 6'b100000 : 6'b000000;
        end

        RESET_N = 1'b0;
        SW      = '0;
        model_clear();
        #1;
        check("init_db",   SW_DB,   '0);
        check("init_busy", SW_BUSY, '0);
        step();
        step();
        RESET_N = 1'b1;

        for (int k = 0; k < 8; k++) begin
            SW = tbl[k].sw;
            step();
            check("tbl_db",   SW_DB,   tbl[k].db);
            check("tbl_busy", SW_BUSY, tbl[k].busy);
            check("tbl_rise", SW_RISE, pmask(tbl[k].rise));
            check("tbl_fall", SW_FALL, '0);
        end

        // All switches held at 1 through reset
        SW = 6'b111111;
        reset_pulse(2);
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 6) check("t1_db_e6", SW_DB, '0);
            if (k == 7) begin
                check("t1_db_e7",   SW_DB,   6'b111111);
                check("t1_rise_e7", SW_RISE, pmask(6'b111111));
            end
            if (k == 8) check("t1_rise_e8", SW_RISE, '0);
        end

        // SW[2] bounces, then holds 1
        SW = '0;
        repeat (10) step();
        check_bit("t3_pre_db2", SW_DB[2], 1'b0);
        rise_cnt = 0;
        v = 6'b101000;
        for (int b = 0; b < 4; b++) begin
            SW[2] = v[b];
            step();
            rise_cnt += int'(SW_RISE[2]);
            check_bit("t3_bounce_db2", SW_DB[2], 1'b0);
        end
        SW[2] = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            rise_cnt += int'(SW_RISE[2]);
            if (k == 6) check_bit("t3_db2_e6", SW_DB[2], 1'b0);
            if (k == 7) check_bit("t3_db2_e7", SW_DB[2], 1'b1);
        end
        check_bit("t3_rise_count", rise_cnt == 1, PULSE_EN);

        // SW[1] falls while SW[4] rises on the same edge
        SW = 6'b011000;
        repeat (10) step();
        SW[1] = 1'b0;
        SW[4] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 6) begin
                check_bit("t4_db1_e6", SW_DB[1], 1'b1);
                check_bit("t4_db4_e6", SW_DB[4], 1'b0);
            end
            if (k == 7) begin
                check_bit("t4_db1_e7",   SW_DB[1],   1'b0);
                check_bit("t4_db4_e7",   SW_DB[4],   1'b1);
                check_bit("t4_fall1_e7", SW_FALL[1], PULSE_EN);
                check_bit("t4_rise4_e7", SW_RISE[4], PULSE_EN);
                check_bit("t4_rise1_e7", SW_RISE[1], 1'b0);
            end
        end

        // SW[3] change discarded by reset while pending, then re-qualified
        SW = '0;
        reset_pulse(2);
        SW[3] = 1'b1;
        repeat (4) step();
        check_bit("t5_busy3_pre", SW_BUSY[3], 1'b1);
        reset_pulse(2);
        rise_cnt = 0;
        fall_cnt = 0;
        for (int k = 1; k <= 9; k++) begin
            step();
            rise_cnt += int'(SW_RISE[3]);
            fall_cnt += int'(SW_FALL[3]);
            if (k == 6) check_bit("t5_db3_e6", SW_DB[3], 1'b0);
            if (k == 7) check_bit("t5_db3_e7", SW_DB[3], 1'b1);
        end
        check_bit("t5_rise_count", rise_cnt == 1, PULSE_EN);
        check_bit("t5_fall_count", fall_cnt == 0, 1'b1);

        // Randomized toggling in alternating calm/bouncy phases with occasional resets
        for (int c = 0; c < 3000; c++) begin
            calm = ((c / 64) % 2) == 0;
            if ($urandom_range(0, 199) == 0) begin
                reset_pulse(int'($urandom_range(1, 3)));
            end else begin
                for (int i = 0; i < N; i++) begin
                    if ($urandom_range(0, calm ? 15 : 2) == 0) SW[i] = ~SW[i];
                end
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
